// File: rtl/hc_pkg.sv
// Shared constants and helpers for the 74HC595-style shift/storage register.
// Only the default width and the bit-counter width function live here.
package hc_pkg;

    localparam int HC_DEFAULT_WIDTH = 8;

    // Smallest counter width that can hold 0..width-1, never less than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = 1;
        while ((1 << w) < width) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/hc595_shift_stage.sv
// Serial-in shift stage: holds the shift register, the in-frame bit counter
// and the registered end-of-frame pulse.
module hc595_shift_stage
    import hc_pkg::*;
#(
    parameter int WIDTH = HC_DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ser,
    input  logic             sh_en,
    input  logic             clr,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] sr_shifted,
    output logic             frame_edge,
    output logic             frame_done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic          shift_acc;

    assign shift_acc  = sh_en & ~clr;
    assign sr_shifted = {sr[WIDTH-2:0], ser};

    // High on the edge that takes the last bit of a frame.
    assign frame_edge = shift_acc && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_edge;
            if (clr) begin
                sr  <= '0;
                cnt <= '0;
            end else if (sh_en) begin
                sr  <= sr_shifted;
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hc595_sr.sv
// Top of the 74HC595-style register: shift stage plus storage register,
// optional auto-load at frame end, and active-low output gating.
module hc595_sr
    import hc_pkg::*;
#(
    parameter int WIDTH   = HC_DEFAULT_WIDTH,
    parameter int AUTO_LD = 0
)
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Ser,
    input  logic             Sh_En,
    input  logic             Ld,
    input  logic             Clr,
    input  logic             Oe_N,
    output logic [WIDTH-1:0] Q,
    output logic             Q_S,
    output logic             Frame_Done
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic             frame_edge;
    logic             auto_hit;
    logic [WIDTH-1:0] stg;

    hc595_shift_stage #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk        (Clk),
        .rst        (Rst),
        .ser        (Ser),
        .sh_en      (Sh_En),
        .clr        (Clr),
        .sr         (sr),
        .sr_shifted (sr_shifted),
        .frame_edge (frame_edge),
        .frame_done (Frame_Done)
    );

    assign auto_hit = (AUTO_LD != 0) ? frame_edge : 1'b0;

    // Auto-load captures the post-shift word and wins over an explicit Ld,
    // which otherwise copies the pre-edge shift contents.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stg <= '0;
        end else if (auto_hit) begin
            stg <= sr_shifted;
        end else if (Ld) begin
            stg <= sr;
        end
    end

    assign Q   = Oe_N ? '0 : stg;
    assign Q_S = sr[WIDTH-1];

endmodule

// File: tb/tb_hc595_sr.sv
// Self-checking bench for hc595_sr: table-driven frame vectors, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_hc595_sr;

    localparam int W = 8;

    logic clk;
    logic rst;
    logic ser, sh_en, ld, clr, oe_n;
    logic [W-1:0] q_m, q_a;
    logic qs_m, qs_a, fd_m, fd_a;

    logic c_ser, c_sh, c_ld;
    logic [W-1:0] q_up, q_dn;
    logic qs_up, qs_dn, fd_up, fd_dn;

    int checks;
    int failures;

    // Model state: index 0 = manual-load instance, index 1 = auto-load instance.
    int m_sr[2];
    int m_cnt[2];
    int m_stg[2];
    int m_fd[2];

    typedef struct {
        bit       ser;
        bit       sh;
        bit       ld;
        bit       clr;
        bit       oe_n;
        bit [7:0] exp_q;
        bit       exp_qs;
        bit       exp_fd;
    } vec_t;

    vec_t vecs[12];

    hc595_sr #(.WIDTH(W), .AUTO_LD(0)) u_dut (
        .Clk(clk), .Rst(rst), .Ser(ser), .Sh_En(sh_en), .Ld(ld), .Clr(clr),
        .Oe_N(oe_n), .Q(q_m), .Q_S(qs_m), .Frame_Done(fd_m)
    );

    hc595_sr #(.WIDTH(W), .AUTO_LD(1)) u_auto (
        .Clk(clk), .Rst(rst), .Ser(ser), .Sh_En(sh_en), .Ld(ld), .Clr(clr),
        .Oe_N(oe_n), .Q(q_a), .Q_S(qs_a), .Frame_Done(fd_a)
    );

    hc595_sr #(.WIDTH(W), .AUTO_LD(0)) u_up (
        .Clk(clk), .Rst(rst), .Ser(c_ser), .Sh_En(c_sh), .Ld(c_ld), .Clr(1'b0),
        .Oe_N(1'b0), .Q(q_up), .Q_S(qs_up), .Frame_Done(fd_up)
    );

    hc595_sr #(.WIDTH(W), .AUTO_LD(0)) u_dn (
        .Clk(clk), .Rst(rst), .Ser(qs_up), .Sh_En(c_sh), .Ld(c_ld), .Clr(1'b0),
        .Oe_N(1'b0), .Q(q_dn), .Q_S(qs_dn), .Frame_Done(fd_dn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_sr[k]  = 0;
            m_cnt[k] = 0;
            m_stg[k] = 0;
            m_fd[k]  = 0;
        end
    endtask

    // Behavioural view of one clock edge for the two model instances.
    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            int post;
            bit hit;
            hit  = sh_en && !clr && (m_cnt[k] == W - 1);
            post = ((m_sr[k] << 1) | int'(ser)) % (1 << W);
            if (ld) m_stg[k] = m_sr[k];
            if (k == 1 && hit) m_stg[k] = post;
            m_fd[k] = hit ? 1 : 0;
            if (clr) begin
                m_sr[k]  = 0;
                m_cnt[k] = 0;
            end else if (sh_en) begin
                m_sr[k]  = post;
                m_cnt[k] = (m_cnt[k] + 1) % W;
            end
        end
    endtask

    task automatic checkOutput();
        check("q_main",  int'(q_m),  oe_n ? 0 : m_stg[0]);
        check("qs_main", int'(qs_m), (m_sr[0] >> (W - 1)) & 1);
        check("fd_main", int'(fd_m), m_fd[0]);
        check("q_auto",  int'(q_a),  oe_n ? 0 : m_stg[1]);
        check("qs_auto", int'(qs_a), (m_sr[1] >> (W - 1)) & 1);
        check("fd_auto", int'(fd_a), m_fd[1]);
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        ser   = v.ser;
        sh_en = v.sh;
        ld    = v.ld;
        clr   = v.clr;
        oe_n  = v.oe_n;
        step();
        check($sformatf("vec%0d_q", idx),  int'(q_m),  int'(v.exp_q));
        check($sformatf("vec%0d_qs", idx), int'(qs_m), int'(v.exp_qs));
        check($sformatf("vec%0d_fd", idx), int'(fd_m), int'(v.exp_fd));
    endtask

    task automatic idleInputs();
        ser = 0; sh_en = 0; ld = 0; clr = 0; oe_n = 0;
        c_ser = 0; c_sh = 0; c_ld = 0;
    endtask

    // Reset asserted mid-cycle must clear outputs before any clock edge.
    task automatic doReset();
        idleInputs();
        #2;
        rst = 1'b1;
        #1;
        check("rst_q_main",  int'(q_m),  0);
        check("rst_qs_main", int'(qs_m), 0);
        check("rst_fd_main", int'(fd_m), 0);
        check("rst_q_auto",  int'(q_a),  0);
        check("rst_q_up",    int'(q_up), 0);
        check("rst_q_dn",    int'(q_dn), 0);
        modelReset();
        @(posedge clk);
        #1;
        check("rst_hold_q", int'(q_m), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idleInputs();
        modelReset();
        rst = 1'b1;
        #12;
        check("init_q",  int'(q_m),  0);
        check("init_qs", int'(qs_m), 0);
        check("init_fd", int'(fd_m), 0);
        rst = 1'b0;

        //          ser sh ld clr oe  q      qs fd
        vecs[0]  = '{1, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[6]  = '{1, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 8'h00, 1, 1};
        vecs[8]  = '{0, 0, 1, 0, 0, 8'hB2, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 1, 8'h00, 1, 0};
        vecs[10] = '{1, 1, 1, 0, 0, 8'hB2, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 8'h65, 0, 0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
        end

        doReset();

        // Clear beats a simultaneous shift and restarts the frame count.
        ser = 1; sh_en = 1;
        for (int i = 0; i < 13; i++) step();
        check("clr_pre_qs", int'(qs_m), 1);
        clr = 1;
        step();
        check("clr_qs", int'(qs_m), 0);
        clr = 0; sh_en = 0; ld = 1;
        step();
        check("clr_load_q", int'(q_m), 0);
        ld = 0; sh_en = 1; ser = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("clr_fd_shift%0d", i), int'(fd_m), (i == 8) ? 1 : 0);
        end

        doReset();

        // Auto-load: storage updates together with the Frame_Done pulse.
        sh_en = 1;
        for (int i = W - 1; i >= 0; i--) begin
            ser = (8'hA5 >> i) & 1'b1;
            step();
        end
        check("auto_q",  int'(q_a),  8'hA5);
        check("auto_fd", int'(fd_a), 1);
        sh_en = 0; ser = 0;
        oe_n = 1;
        #1;
        check("auto_oe_off", int'(q_a), 0);
        oe_n = 0;
        #1;
        check("auto_oe_on", int'(q_a), 8'hA5);

        doReset();

        // Two instances chained through Q_S; a common Ld splits the word.
        c_sh = 1;
        for (int i = 15; i >= 0; i--) begin
            c_ser = (16'h1234 >> i) & 1'b1;
            step();
        end
        c_sh = 0; c_ld = 1;
        step();
        c_ld = 0;
        check("casc_up", int'(q_up), 8'h34);
        check("casc_dn", int'(q_dn), 8'h12);

        doReset();

        for (int i = 0; i < 400; i++) begin
            ser   = $urandom_range(0, 1);
            sh_en = ($urandom_range(0, 3) != 0);
            ld    = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            oe_n  = ($urandom_range(0, 7) == 0);
            step();
            if (i % 137 == 136) doReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
